// File: rtl/kmeans_image_tx.sv
// kmeans_image_tx: buffers one upstream image job (config beat plus pixels),
// then replays it to the k-means system as start, header and a gap-free pixel stream.
module kmeans_image_tx #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned K_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_size,
    input  logic [K_W-1:0]    cfg_k,
    output logic              cfg_ready,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              start,
    output logic              newImage,
    output logic [DATA_W-1:0] serialOut,
    output logic              serial_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REARM,
        S_START,
        S_HEADER,
        S_STREAM,
        S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] size_q;
    logic [K_W-1:0]    k_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              sent_once;
    logic [DATA_W-1:0] mem [DEPTH];

    // Image buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && pix_ready && pix_valid) begin
            mem[wr_ptr] <= pix_data;
        end
    end

    // Job sequencer: every output is set one cycle ahead so it is registered in its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cfg_ready    <= 1'b0;
            pix_ready    <= 1'b0;
            start        <= 1'b0;
            newImage     <= 1'b0;
            serialOut    <= '0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            size_q       <= '0;
            k_q          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sent_once    <= 1'b0;
        end else begin
            start    <= 1'b0;
            newImage <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        size_q    <= cfg_size;
                        k_q       <= cfg_k;
                        wr_ptr    <= '0;
                        cfg_ready <= 1'b0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pix_valid && pix_ready) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        // Equality on the last index avoids ever forming size+1.
                        if (wr_ptr == size_q) begin
                            pix_ready <= 1'b0;
                            if (sent_once) begin
                                newImage <= 1'b1;
                                state    <= S_REARM;
                            end else begin
                                start <= 1'b1;
                                state <= S_START;
                            end
                        end
                    end
                end
                S_REARM: begin
                    start <= 1'b1;
                    state <= S_START;
                end
                S_START: begin
                    rd_ptr       <= '0;
                    serial_valid <= 1'b1;
                    serialOut    <= DATA_W'({k_q, size_q});
                    state        <= S_HEADER;
                end
                S_HEADER: begin
                    // First pixel fetch happens here so pixel 0 follows the header directly.
                    serialOut <= mem[rd_ptr];
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (rd_ptr == size_q) begin
                        serial_valid <= 1'b0;
                        serialOut    <= '0;
                        done         <= 1'b1;
                        state        <= S_FIN;
                    end else begin
                        rd_ptr    <= rd_ptr + ADDR_W'(1);
                        serialOut <= mem[rd_ptr + ADDR_W'(1)];
                    end
                end
                S_FIN: begin
                    sent_once <= 1'b1;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_image_tx.sv
// Randomized self-checking bench for kmeans_image_tx against a transaction-level model.
module tb_kmeans_image_tx;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned K_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic [ADDR_W-1:0] cfg_size;
    logic [K_W-1:0]    cfg_k;
    logic              cfg_ready;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              start;
    logic              newImage;
    logic [DATA_W-1:0] serialOut;
    logic              serial_valid;
    logic              busy;
    logic              done;

    kmeans_image_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .K_W(K_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_size(cfg_size), .cfg_k(cfg_k), .cfg_ready(cfg_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .start(start), .newImage(newImage), .serialOut(serialOut),
        .serial_valid(serial_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              st;
        logic              ni;
        logic              sv;
        logic              dn;
        logic              bz;
        logic              cr;
        logic [DATA_W-1:0] so;
    } obs_t;

    obs_t              log_q[$];
    logic [DATA_W-1:0] job_pix[$];
    int                errors = 0;
    int                checks = 0;
    bit                prev_done = 1'b0;   // a job has completed since the last reset

    task automatic rec();
        obs_t o;
        o.st = start; o.ni = newImage; o.sv = serial_valid; o.dn = done;
        o.bz = busy;  o.cr = cfg_ready; o.so = serialOut;
        log_q.push_back(o);
    endtask

    // Drive one job and check the observed cycle trace against the protocol model.
    task automatic run_job(input string name, input int size, input int k,
                           input bit gaps, input bit junk);
        int n = size + 1;
        int idx = 0;
        int cyc = 0;
        bit ok = 0;
        bit tog = 1;
        bit pv;
        int s = -1, starts = 0, news = 0, new_idx = -1, svs = 0;
        int dones = 0, done_idx = -1, zero_bad = 0;
        logic [DATA_W-1:0] exp_q[$];

        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cfg_ready_wait: got %b want 1", name, cfg_ready);
            return;
        end
        log_q.delete();
        cfg_valid = 1'b1; cfg_size = ADDR_W'(size); cfg_k = K_W'(k);
        @(negedge clk); rec();
        cfg_valid = 1'b0; cfg_size = ADDR_W'($urandom); cfg_k = K_W'($urandom);

        while (idx < n && cyc < 20 * n + 50) begin
            pv = gaps ? tog : 1'b1;
            tog = ~tog;
            pix_valid = pv;
            pix_data  = pv ? job_pix[idx] : DATA_W'($urandom);
            if (junk && cyc == 2) begin
                cfg_valid = 1'b1;
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cfg_ready_in_load: got %b want 0", name, cfg_ready);
                end
            end else begin
                cfg_valid = 1'b0;
            end
            if (pv && pix_ready === 1'b1) idx++;
            @(negedge clk); rec();
            cyc++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (idx < n) begin
            errors++;
            $display("FAIL %s load_timeout: accepted %0d want %0d", name, idx, n);
            pix_valid = 1'b0;
            return;
        end
        // Junk pixels after the last one must be ignored.
        pix_valid = junk;
        pix_data  = DATA_W'($urandom);

        ok = 0;
        for (int c = 0; c < n + 20 && !ok; c++) begin
            @(negedge clk); rec();
            if (done === 1'b1) ok = 1;
        end
        @(negedge clk); rec();
        pix_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_timeout: got %b want 1", name, done);
            return;
        end

        exp_q.push_back(DATA_W'(k * 4096 + size));
        foreach (job_pix[i]) exp_q.push_back(job_pix[i]);

        foreach (log_q[i]) begin
            if (log_q[i].st === 1'b1) begin starts++; if (s < 0) s = i; end
            if (log_q[i].ni === 1'b1) begin news++; new_idx = i; end
            if (log_q[i].sv === 1'b1) svs++;
            if (log_q[i].sv !== 1'b1 && log_q[i].so !== '0) zero_bad++;
            if (log_q[i].dn === 1'b1) begin dones++; done_idx = i; end
        end

        checks++;
        if (starts != 1 || s < 0) begin
            errors++;
            $display("FAIL %s start_count: got %0d want 1", name, starts);
            return;
        end
        checks++;
        if (news != (prev_done ? 1 : 0)) begin
            errors++;
            $display("FAIL %s newimage_count: got %0d want %0d", name, news, prev_done ? 1 : 0);
        end
        if (prev_done) begin
            checks++;
            if (new_idx != s - 1) begin
                errors++;
                $display("FAIL %s newimage_pos: got %0d want %0d", name, new_idx, s - 1);
            end
        end
        checks++;
        if (log_q[s].bz !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_start: got %b want 1", name, log_q[s].bz);
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            if (s + 1 + j >= log_q.size()) begin
                errors++;
                $display("FAIL %s word%0d: trace too short want %06h", name, j, exp_q[j]);
            end else if (log_q[s+1+j].sv !== 1'b1 || log_q[s+1+j].so !== exp_q[j]) begin
                errors++;
                $display("FAIL %s word%0d: got sv=%b %06h want sv=1 %06h", name, j,
                         log_q[s+1+j].sv, log_q[s+1+j].so, exp_q[j]);
            end
        end
        checks++;
        if (svs != n + 1) begin
            errors++;
            $display("FAIL %s serial_valid_count: got %0d want %0d", name, svs, n + 1);
        end
        checks++;
        if (dones != 1 || done_idx != s + 2 + n) begin
            errors++;
            $display("FAIL %s done_pos: got count=%0d at %0d want 1 at %0d", name, dones,
                     done_idx, s + 2 + n);
        end
        checks++;
        if (zero_bad != 0) begin
            errors++;
            $display("FAIL %s serialout_idle_zero: got %0d nonzero cycles want 0", name, zero_bad);
        end
        checks++;
        if (log_q[log_q.size()-1].cr !== 1'b1 || log_q[log_q.size()-1].bz !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: got cfg_ready=%b busy=%b want 1 0", name,
                     log_q[log_q.size()-1].cr, log_q[log_q.size()-1].bz);
        end
        prev_done = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_valid = 1'b0; cfg_size = '0; cfg_k = '0;
        pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready, pix_ready, start, newImage, serial_valid, busy, done} !== 7'b0 ||
            serialOut !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b%b so=%06h want all 0", cfg_ready,
                     pix_ready, start, newImage, serial_valid, busy, done, serialOut);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got cfg_ready=%b busy=%b want 1 0", cfg_ready, busy);
        end
        prev_done = 1'b0;
    endtask

    task automatic test_basic();
        job_pix.delete();
        job_pix.push_back(24'h111111); job_pix.push_back(24'h222222);
        job_pix.push_back(24'h333333); job_pix.push_back(24'h444444);
        run_job("basic", 3, 4, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        job_pix.delete();
        job_pix.push_back(24'hABCDEF);
        run_job("single", 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        job_pix.delete();
        for (int i = 0; i < 8; i++) job_pix.push_back(DATA_W'($urandom));
        run_job("stall", 7, int'($urandom_range(0, 15)), 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int cnt = 0;
        int starts = 0;
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) ok = 1;
        end
        cfg_valid = 1'b1; cfg_size = ADDR_W'(7); cfg_k = K_W'(2);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            pix_valid = 1'b1;
            pix_data  = DATA_W'($urandom);
            if (pix_ready === 1'b1) idx++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        for (int c = 0; c < 40 && cnt < 3; c++) begin
            if (serial_valid === 1'b1) cnt++;
            if (cnt < 3) @(negedge clk);
        end
        checks++;
        if (cnt < 3) begin
            errors++;
            $display("FAIL rstmid_reach_stream: got %0d words want 3", cnt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (serial_valid !== 1'b0 || serialOut !== '0 || busy !== 1'b0 ||
            cfg_ready !== 1'b0 || start !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async_clear: got sv=%b so=%06h busy=%b cr=%b want 0", serial_valid,
                     serialOut, busy, cfg_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (start === 1'b1 || serial_valid === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", starts);
        end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: got cfg_ready=%b want 1", cfg_ready);
        end
        prev_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 2; j++) begin
            int sz = int'($urandom_range(0, 12));
            job_pix.delete();
            for (int i = 0; i <= sz; i++) job_pix.push_back(DATA_W'($urandom));
            run_job(j == 0 ? "b2b_first" : "b2b_second", sz, int'($urandom_range(0, 15)),
                    1'b0, 1'b0);
        end
    endtask

    task automatic test_max();
        int base = int'($urandom_range(0, 1000));
        job_pix.delete();
        for (int i = 0; i < 4096; i++) job_pix.push_back(DATA_W'(base + i));
        run_job("max", 4095, int'($urandom_range(0, 15)), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_max();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kmeans_image_tx.md
Name: kmeans_image_tx

Overview:
- Transmitter side of the k-means serial image-load protocol. The k-means system core is the receiver.
- Accepts one image job from an upstream source: a config beat, then pixels on valid/ready handshakes.
- Buffers the whole image internally, then replays it to the k-means system as a gap-free stream:
  - a `start` pulse,
  - a header word,
  - one 24-bit pixel per clock.
- Sequences `newImage` between consecutive jobs.

Parameters:
- DATA_W, 24, pixel/serial word width (RGB 8:8:8).
- ADDR_W, 12, pixel index width; image buffer depth = 2**ADDR_W.
- K_W, 4, cluster-count field width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config beat valid.
- cfg_size  input  ADDR_W  index of last pixel (pixel count minus 1).
- cfg_k  input  K_W  number of active cluster cores.
- cfg_ready  output  1  config accepted when cfg_valid && cfg_ready.
- pix_valid  input  1  upstream pixel valid.
- pix_data  input  DATA_W  upstream pixel.
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
- start  output  1  one-cycle start strobe to the k-means system.
- newImage  output  1  one-cycle re-arm strobe to the k-means system.
- serialOut  output  DATA_W  header/pixel word, drives the system serial input.
- serial_valid  output  1  high while serialOut carries a header or pixel word (bench/monitor use).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last pixel is driven.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: state=IDLE; cfg_ready=0, pix_ready=0, start=0, newImage=0, serialOut=0, serial_valid=0, busy=0, done=0.
  - Internal: sent_once=0, wr_ptr=0, rd_ptr=0. Buffer contents undefined.
  - Reset mid-operation aborts immediately. No further start or serial words until a new job.
- All outputs are registered. serialOut=0 whenever serial_valid=0.
- States:
  - IDLE: cfg_ready=1. On cfg_valid:
    - latch size=cfg_size and k=cfg_k;
    - wr_ptr=0;
    - go to LOAD.
  - LOAD: pix_ready=1. On each handshake: mem[wr_ptr]=pix_data, wr_ptr+1.
    - When a handshake occurs with wr_ptr==size, go to REARM if sent_once=1, else go to START.
    - pix_valid gaps stall LOAD indefinitely. pix_ready=0 in every other state.
  - REARM: newImage=1 for exactly this one cycle, then go to START.
  - START: start=1 for exactly this one cycle; rd_ptr=0; go to HEADER.
  - HEADER: serial_valid=1 and serialOut={8'h00, k, size} (bits [23:16]=0, [15:12]=k, [11:0]=size); go to STREAM.
  - STREAM: serial_valid=1 and serialOut=mem[rd_ptr], then rd_ptr+1.
    - After the cycle with rd_ptr==size, go to FIN.
    - Exactly size+1 pixel words, contiguous, no gaps.
  - FIN: done=1 for one cycle; sent_once=1; go to IDLE.
- Receiver timing contract:
  - start is sampled at edge N;
  - the header must be stable through edge N+1;
  - pixel i is stable through edge N+2+i.
  - Hence START, HEADER and STREAM are back-to-back with no idle cycles.
- Widths: size+1 is never computed. The terminal test is an equality on ADDR_W-bit pointers, so size=4095 works without overflow.
- Boundaries:
  - cfg_size=0 gives one pixel word.
  - cfg_k is passed through unchecked; 0 is legal.
  - cfg_valid outside IDLE is ignored; cfg_ready=0.
  - pix_valid outside LOAD is ignored and does not write.
  - A handshake on the same cycle as the LOAD exit is the last pixel; no extra write.
- Read latency: the buffer read address is presented one cycle ahead so that serialOut is registered data. The first pixel read is launched in HEADER.

Test Plan:
- Job size=3, k=4, pixels 0x111111, 0x222222, 0x333333, 0x444444 with continuous pix_valid -> after the 4th handshake, start high 1 cycle; next cycle serialOut=0x004003; then the 4 pixels on 4 consecutive cycles; done pulses on the cycle after 0x444444; newImage never asserted.
- size=0, k=1, pixel 0xABCDEF -> start; header 0x001000; single word 0xABCDEF; done; back to IDLE with cfg_ready=1.
- size=7 with pix_valid toggling 1/0 -> LOAD stalls and only 8 writes occur; stream is still 8 contiguous words in order, with no gap between header and pixel 0.
- Two back-to-back jobs -> first job has no newImage; second job has newImage high exactly 1 cycle, immediately before start.
- reset asserted during STREAM after 2 pixels -> serial_valid=0, serialOut=0, busy=0 asynchronously. After release: cfg_ready=1, sent_once=0, so the next job has no newImage.
- size=4095, incrementing pixel pattern -> 4096 words after header 0x00?FFF (k nibble); last word = pattern[4095]; no wrap or early termination.
